vector_ram_slave: RTL
=====================

# vector_ram_slave

Multi-lane register-file memory that terminates the slave side of `vector_ram_if`. It sits directly downstream of any vector master: it accepts PARALLELISM-wide read or write requests, executes them against one shared array of 2^ADDR_WIDTH words, and returns a single buffered response. Write requests return a completion on the b channel; read requests return all lane data on the r channel. Both channels honour master backpressure.

## Interface
- ADDR_WIDTH, 5: address bits per lane; array depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- PARALLELISM, 3: number of lanes per request.

- clk  input  1  sole clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus  modport  `vector_ram_if.slave`  parameters must match. Inputs: addr[], wdata[], write, valid, bready, rready. Outputs: ready, bdata, bvalid, rdata[], rvalid.

## Operation
- **Request accept:** valid && ready at a rising edge; write selects the type.
- **Write request:**
  - For each lane i, mem[addr[i]] <= wdata[i].
  - Lanes that share an address resolve so that the highest lane index wins.
  - wcount <= wcount+1, wrapping mod 2^DATA_WIDTH.
  - A b response is loaded with bdata = the incremented wcount.
- **Read request:**
  - A response is loaded with rdata[i] = mem[addr[i]], using the array contents before this edge.
  - Any number of lanes may read the same address.
- **Response slot:** a single registered slot, held in the state `resp_q` ∈ {RESP_NONE, RESP_B, RESP_R}.
  - RESP_NONE -> RESP_B on an accepted write.
  - RESP_NONE -> RESP_R on an accepted read.
  - RESP_B -> RESP_NONE on bready, or -> RESP_B/RESP_R if a new request is accepted in the same cycle.
  - RESP_R behaves the same way using rready.
- **Outputs derived from `resp_q`:**
  - bvalid = (resp_q==RESP_B).
  - rvalid = (resp_q==RESP_R).
  - bdata and rdata hold stable while their valid is high and unhandshaken.
- **Ready:** ready = !rst && (resp_q==RESP_NONE || the current response's handshake occurs this cycle). This is combinational from bready/rready; there is no combinational path from valid to ready.
- **Unused channel:** bready while not bvalid has no effect; likewise rready while not rvalid.
- **Reset:**
  - Array cleared to 0, wcount=0, resp_q=RESP_NONE.
  - bdata=0, rdata[*]=0, bvalid=0, rvalid=0, ready=0 while rst is high.
  - Asserting rst mid-response drops the pending response; it is never delivered.
  - A request presented during reset is not accepted.

## Timing
- Latency: a request accepted at edge N has its response valid in the cycle after edge N (1 cycle).
- Throughput: 1 request/cycle when the master holds bready/rready high.
- Read-after-write: write accepted at N, read of the same address accepted at N+1 returns the new data.
- Stall: while a response is pending and not handshaken, ready=0 and the response outputs are frozen.
- The first accept can occur on the first edge after rst deasserts.

## Structure
- Package `vector_ram_pkg`: enum `resp_kind_e` {RESP_NONE, RESP_B, RESP_R}; lane-index width constant $clog2(PARALLELISM).
- One natural sub-module, `vector_ram_array`:
  - Flop array with PARALLELISM write ports (highest lane wins) and PARALLELISM asynchronous read ports.
  - Synchronous clear on rst.
- The top level holds the response slot, wcount and the ready logic.

## Test plan
All scenarios use default parameters (ADDR_WIDTH=5, DATA_WIDTH=32, PARALLELISM=3).
- **Reset read:** read addr={0,5,31} right after reset -> rvalid the next cycle, rdata={0,0,0}; bvalid stays 0.
- **Write then read back:**
  - Write addr={1,2,3}, wdata={A,B,C}, bready=1 -> bvalid one cycle later, bdata=1.
  - Read {3,2,1} -> rdata={C,B,A}.
- **Lane conflict and duplicate reads:**
  - Write addr={7,7,7}, wdata={1,2,3} -> subsequent read {7,7,7} returns {3,3,3}.
- **Backpressure:**
  - Read with rready=0 for 4 cycles -> ready=0, rdata stable, rvalid held.
  - Raise rready together with a queued write -> handshake and accept in the same edge; bvalid the next cycle.
- **Back-to-back writes:** 10 writes with bready=1 -> one accept per cycle, bdata=1..10 consecutively; a read at cycle 11 sees the last data.
- **Reset mid-response:**
  - Pending rvalid with rready=0, then assert rst for 1 cycle -> rvalid=0, ready=0 during reset.
  - A read afterwards returns 0 (array cleared).
  - The next write returns bdata=1.

Source files
------------

// File: rtl/vector_ram_pkg.sv
// Shared types and constants for the vector RAM slave and its storage array.
package vector_ram_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_B    = 2'd1,
    RESP_R    = 2'd2
  } resp_kind_e;

  localparam int DEF_ADDR_WIDTH  = 5;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_PARALLELISM = 3;
  localparam int LANE_IDX_W      = $clog2(DEF_PARALLELISM);

endpackage

// File: rtl/vector_ram_if.sv
// Multi-lane request bus with a buffered b (write completion) and r (read data) response.
interface vector_ram_if #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 3
);
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata;
  logic                                   write;
  logic                                   valid;
  logic                                   ready;
  logic [DATA_WIDTH-1:0]                  bdata;
  logic                                   bvalid;
  logic                                   bready;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata;
  logic                                   rvalid;
  logic                                   rready;

  modport master (
    output addr, wdata, write, valid, bready, rready,
    input  ready, bdata, bvalid, rdata, rvalid
  );

  modport slave (
    input  addr, wdata, write, valid, bready, rready,
    output ready, bdata, bvalid, rdata, rvalid
  );
endinterface

// File: rtl/vector_ram_array.sv
// Flop-based word array: PARALLELISM write ports (highest lane wins) and PARALLELISM async read ports.
module vector_ram_array #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   we,
  input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] waddr,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata,
  input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] raddr,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Ascending lane order lets a later lane overwrite an earlier one at the same address.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < PARALLELISM; i++) begin
        mem_d[waddr[i]] = wdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      rdata[i] = mem_q[raddr[i]];
    end
  end
endmodule

// File: rtl/vector_ram_slave.sv
// Slave terminating vector_ram_if: executes lane requests on a shared array, one buffered response slot.
module vector_ram_slave
  import vector_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PARALLELISM = DEF_PARALLELISM
) (
  input  logic       clk,
  input  logic       rst,
  vector_ram_if.slave bus
);
  resp_kind_e resp_q, resp_d;

  logic hs_b, hs_r, ready, accept, wr_accept, rd_accept;

  logic [DATA_WIDTH-1:0]                  wcount_q, wcount_d;
  logic [DATA_WIDTH-1:0]                  bdata_q, bdata_d;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rd_word;

  vector_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PARALLELISM(PARALLELISM)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_accept),
    .waddr(bus.addr),
    .wdata(bus.wdata),
    .raddr(bus.addr),
    .rdata(rd_word)
  );

  // The slot frees up in the same cycle its handshake completes, so ready never depends on valid.
  always_comb begin
    hs_b      = (resp_q == RESP_B) && bus.bready;
    hs_r      = (resp_q == RESP_R) && bus.rready;
    ready     = !rst && ((resp_q == RESP_NONE) || hs_b || hs_r);
    accept    = bus.valid && ready;
    wr_accept = accept && bus.write;
    rd_accept = accept && !bus.write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  always_comb begin
    resp_d = resp_q;
    if (wr_accept) begin
      resp_d = RESP_B;
    end else if (rd_accept) begin
      resp_d = RESP_R;
    end else if (hs_b || hs_r) begin
      resp_d = RESP_NONE;
    end
  end

  always_comb begin
    wcount_d = wcount_q;
    bdata_d  = bdata_q;
    rdata_d  = rdata_q;
    if (wr_accept) begin
      wcount_d = wcount_q + 1'b1;
      bdata_d  = wcount_q + 1'b1;
    end
    if (rd_accept) begin
      rdata_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcount_q <= '0;
      bdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wcount_q <= wcount_d;
      bdata_q  <= bdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs are forced quiet while rst is high, dropping any response still held in the slot.
  always_comb begin
    bus.ready  = ready;
    bus.bvalid = !rst && (resp_q == RESP_B);
    bus.rvalid = !rst && (resp_q == RESP_R);
    bus.bdata  = rst ? '0 : bdata_q;
    bus.rdata  = rst ? '0 : rdata_q;
  end
endmodule
